block_led_fader: RTL and testbench

Register-mapped LED fade engine that sits between `block_spi_slave` and the `block_pwm` instances. It consumes the SPI slave's address/data write strobes and holds a target brightness per channel. It ramps each channel's live duty cycle toward its target at a programmable rate and step size, so the host issues one write per transition. Channel outputs drive the `duty_cycle` inputs of the PWM blocks directly.

---
 rtl/block_led_fader.sv | 134 +++++++++++++
 tb/tb_block_led_fader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/block_led_fader.sv
// LED fade engine: per-channel target registers written over the SPI strobe bus,
// with live duty ramped toward each target on a prescaled scan tick.

module fader_lane (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_tgt,
    input  logic       snap,
    input  logic [7:0] wdata,
    input  logic       upd,
    input  logic [7:0] step,
    output logic [7:0] cur,
    output logic       match
);
    logic [7:0] tgt;
    logic [8:0] up_gap, dn_gap;
    logic [7:0] nxt;

    assign up_gap = {1'b0, tgt} - {1'b0, cur};
    assign dn_gap = {1'b0, cur} - {1'b0, tgt};
    assign match  = (cur == tgt);

    // Step size is clamped to the remaining gap so the ramp lands exactly on target.
    always_comb begin
        nxt = cur;
        if (cur < tgt)
            nxt = cur + ((step < up_gap[7:0]) ? step : up_gap[7:0]);
        else if (cur > tgt)
            nxt = cur - ((step < dn_gap[7:0]) ? step : dn_gap[7:0]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tgt <= 8'h00;
            cur <= 8'h00;
        end else begin
            if (wr_tgt)
                tgt <= wdata;
            if (wr_tgt && snap)
                cur <= wdata;
            else if (upd)
                cur <= nxt;
        end
    end
endmodule

module block_led_fader #(
    parameter int CHANNELS = 7,
    parameter int PRESCALE = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            address_in,
    input  logic [7:0]            data_in,
    input  logic                  data_ready,
    output logic [8*CHANNELS-1:0] duty_cycle_out,
    output logic                  settled
);
    localparam int CW = $clog2(255 * PRESCALE) + 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    logic [7:0]                rate, step;
    logic [CW-1:0]             cnt, term;
    logic                      tick, rate_wr, step_wr;
    logic [0:0]                state;
    logic [2:0]                idx;
    logic [CHANNELS-1:0][7:0]  cur;
    logic [CHANNELS-1:0]       match;

    assign rate_wr = data_ready && (address_in == 8'd8);
    assign step_wr = data_ready && (address_in == 8'd9);
    assign term    = CW'(rate) * CW'(PRESCALE) - CW'(1);
    assign tick    = (rate != 8'h00) && (cnt == term);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rate <= 8'h00;
            step <= 8'h01;
        end else begin
            if (rate_wr)
                rate <= data_in;
            if (step_wr)
                step <= (data_in == 8'h00) ? 8'h01 : data_in;
        end
    end

    // Snap mode parks the prescaler; any RATE write restarts the tick period.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (rate_wr || rate == 8'h00 || cnt == term)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= 3'd0;
        end else if (state == S_IDLE) begin
            if (tick) begin
                state <= S_SCAN;
                idx   <= 3'd0;
            end
        end else if (idx == 3'(CHANNELS - 1)) begin
            state <= S_IDLE;
            idx   <= 3'd0;
        end else begin
            idx <= idx + 3'd1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_lane
            fader_lane u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .wr_tgt (data_ready && (address_in == 8'(i + 1))),
                .snap   (rate == 8'h00),
                .wdata  (data_in),
                .upd    ((state == S_SCAN) && (idx == 3'(i))),
                .step   (step),
                .cur    (cur[i]),
                .match  (match[i])
            );
        end
    endgenerate

    assign duty_cycle_out = cur;
    assign settled        = &match;
endmodule

// File: tb/tb_block_led_fader.sv
// Bench for block_led_fader: directed scenarios plus random writes, checked every
// cycle against an edge-count based model of targets, ticks and scans.

module tb_block_led_fader;
    localparam int CH = 7;
    localparam int P  = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        address_in = 8'h00;
    logic [7:0]        data_in = 8'h00;
    logic              data_ready = 1'b0;
    logic [8*CH-1:0]   duty_cycle_out;
    logic              settled;

    always #5 clk = ~clk;

    block_led_fader #(.CHANNELS(CH), .PRESCALE(P)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .address_in     (address_in),
        .data_in        (data_in),
        .data_ready     (data_ready),
        .duty_cycle_out (duty_cycle_out),
        .settled        (settled)
    );

    int total = 0;
    int bad   = 0;

    // Model: ticks fall on edges a whole number of periods after the last RATE write;
    // a scan started at edge T moves channel k on edge T+k.
    int     m_tgt[CH];
    int     m_cur[CH];
    int     m_rate, m_step;
    longint m_edge = 0, m_base = 0, m_scan_t = 0;
    bit     m_scan = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h edge=%0d", tag, got, exp, m_edge);
        end
    endtask

    function automatic logic [8*CH-1:0] m_duty();
        logic [8*CH-1:0] v;
        for (int i = 0; i < CH; i++) v[8*i +: 8] = 8'(m_cur[i]);
        return v;
    endfunction

    function automatic logic m_settled();
        for (int i = 0; i < CH; i++) if (m_cur[i] != m_tgt[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input bit r, input bit dr, input int a, input int d);
        bit tick, was_scan;
        int k, gap, mv;
        m_edge++;
        if (!r) begin
            for (int i = 0; i < CH; i++) begin m_tgt[i] = 0; m_cur[i] = 0; end
            m_rate = 0; m_step = 1; m_base = m_edge; m_scan = 0;
            return;
        end
        tick = (m_rate > 0) && (((m_edge - m_base) % (m_rate * P)) == 0);
        was_scan = m_scan;
        if (m_scan) begin
            k   = int'(m_edge - m_scan_t);
            gap = m_tgt[k-1] - m_cur[k-1];
            mv  = (gap < 0) ? -gap : gap;
            if (mv > m_step) mv = m_step;
            m_cur[k-1] += (gap < 0) ? -mv : mv;
            if (k == CH) m_scan = 0;
        end
        if (dr) begin
            if (a >= 1 && a <= CH) begin
                if (m_rate == 0) m_cur[a-1] = d;
                m_tgt[a-1] = d;
            end else if (a == 8) begin
                m_rate = d; m_base = m_edge;
            end else if (a == 9) begin
                m_step = (d == 0) ? 1 : d;
            end
        end
        if (tick && !was_scan) begin
            m_scan = 1; m_scan_t = m_edge;
        end
    endtask

    task automatic cyc(input bit r, input bit dr, input int a, input int d);
        @(negedge clk);
        chk("duty", 64'(duty_cycle_out), 64'(m_duty()));
        chk("settled", 64'(settled), 64'(m_settled()));
        rst_n = r; data_ready = dr; address_in = 8'(a); data_in = 8'(d);
        model_edge(r, dr, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 0, 0);
    endtask

    task automatic wr(input int a, input int d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    int sel_tbl[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 255};

    initial begin
        bit found;
        int a, d;

        rst_n = 1'b0;
        model_edge(1'b0, 1'b0, 0, 0);
        repeat (2) @(posedge clk);

        idle(1000);
        chk("rst_duty", 64'(duty_cycle_out), 64'h0);
        chk("rst_settled", 64'(settled), 64'h1);

        wr(3, 8'h80);
        idle(1);
        chk("snap_ch3", 64'(duty_cycle_out[23:16]), 64'h80);
        chk("snap_others", 64'(duty_cycle_out & ~(56'hFF << 16)), 64'h0);
        chk("snap_settled", 64'(settled), 64'h1);

        wr(8, 1); wr(9, 8'h10); wr(1, 8'h40);
        idle(100);
        chk("ramp_unsettled", 64'(settled), 64'h0);
        idle(1100);
        chk("ramp_ch1", 64'(duty_cycle_out[7:0]), 64'h40);

        wr(9, 8'h30); wr(1, 0); idle(800);
        wr(1, 8'h40); idle(600);
        chk("clamp_up", 64'(duty_cycle_out[7:0]), 64'h40);
        wr(1, 8'h05); idle(600);
        chk("clamp_down", 64'(duty_cycle_out[7:0]), 64'h05);
        wr(9, 0); wr(1, 8'h07); idle(600);

        wr(9, 8'h10);
        for (int k = 1; k <= CH; k++) wr(k, 8'h20 * k);
        found = 0;
        for (int n = 0; n < 1000 && !found; n++) begin
            if (m_scan && m_edge == m_scan_t + 1) found = 1;
            else idle(1);
        end
        chk("coll_wait", 64'(found), 64'h1);
        wr(2, 8'hF0);
        idle(800);

        wr(0, 8'hAA); wr(10, 8'h55); wr(255, 8'h11);
        found = 0;
        for (int n = 0; n < 1000 && !found; n++) begin
            if (m_scan) found = 1;
            else idle(1);
        end
        chk("scan_wait", 64'(found), 64'h1);
        cyc(1'b0, 1'b0, 0, 0);
        idle(1);
        chk("rst2_duty", 64'(duty_cycle_out), 64'h0);
        chk("rst2_settled", 64'(settled), 64'h1);
        wr(4, 8'h33);
        idle(1);
        chk("rst2_rate0", 64'(duty_cycle_out[31:24]), 64'h33);

        for (int n = 0; n < 20000; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                a = sel_tbl[$urandom_range(0, 11)];
                d = (a == 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 255));
                if (a == 9 && $urandom_range(0, 3) == 0) d = 0;
                cyc(1'b1, 1'b1, a, d);
            end else begin
                cyc(($urandom_range(0, 2999) != 0), 1'b0, 0, 0);
            end
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
